uart_rx_byte: RTL and testbench

- UART receiver, 8N1, LSB first. Sits directly upstream of the text-row buffer and drives that buffer's `byteReady`/`data` inputs.
- Synchronises the asynchronous `uartRx` pin and samples each bit at mid-bit.
- Handshake is level-based, matching the buffer's contract:
  - `byteReady` falls when a valid start bit is confirmed.
  - `byteReady` rises when the frame ends, with `data` already stable.
  - `data` is held until the next confirmed start bit.

---
 rtl/uart_rx_byte.sv | 147 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver (LSB first) with a level handshake for the text-row buffer.
// byteReady drops on a confirmed start bit and rises at frame end with data already stable.
module uart_rx_byte #(
   parameter int unsigned DELAY_FRAMES = 234
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uartRx,
   output logic       byteReady,
   output logic [7:0] data,
   output logic       frameErr,
   output logic       rxBusy
);

   localparam int unsigned HALF_DELAY = DELAY_FRAMES / 2;
   localparam int unsigned CNT_W      = $clog2(DELAY_FRAMES + 1);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_DELAY);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DELAY_FRAMES - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic             rxMeta;
   logic             rxS;
   logic [2:0]       state;
   logic [2:0]       stateNext;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counterNext;
   logic [2:0]       bitIdx;
   logic [2:0]       bitIdxNext;
   logic [7:0]       shiftReg;
   logic [7:0]       shiftNext;
   logic             byteReadyNext;
   logic [7:0]       dataNext;
   logic             frameErrNext;
   logic             rxBusyNext;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= uartRx;
         rxS    <= rxMeta;
      end
   end

   // State and datapath register
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         bitIdx    <= 3'd0;
         shiftReg  <= 8'h00;
         byteReady <= 1'b1;
         data      <= 8'h00;
         frameErr  <= 1'b0;
         rxBusy    <= 1'b0;
      end else begin
         state     <= stateNext;
         counter   <= counterNext;
         bitIdx    <= bitIdxNext;
         shiftReg  <= shiftNext;
         byteReady <= byteReadyNext;
         data      <= dataNext;
         frameErr  <= frameErrNext;
         rxBusy    <= rxBusyNext;
      end
   end

   // Next-state and datapath decisions, all made on the synchronised line
   always_comb begin
      stateNext     = state;
      counterNext   = counter + CNT_W'(1);
      bitIdxNext    = bitIdx;
      shiftNext     = shiftReg;
      byteReadyNext = byteReady;
      dataNext      = data;
      frameErrNext  = frameErr;

      case (state)
         IDLE: begin
            counterNext = '0;
            if (!rxS) begin
               stateNext   = START;
               counterNext = CNT_W'(1);
            end
         end
         START: begin
            if (counter == HALF_CNT) begin
               counterNext = '0;
               if (!rxS) begin
                  stateNext     = READ;
                  byteReadyNext = 1'b0;
                  bitIdxNext    = 3'd0;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         READ: begin
            if (counter == BIT_END) begin
               shiftNext[bitIdx] = rxS;
               counterNext       = '0;
               bitIdxNext        = bitIdx + 3'd1;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end
            end
         end
         STOP: begin
            if (counter == BIT_END) begin
               counterNext = '0;
               dataNext    = shiftReg;
               if (rxS) begin
                  frameErrNext  = 1'b0;
                  byteReadyNext = 1'b1;
                  stateNext     = IDLE;
               end else begin
                  frameErrNext = 1'b1;
                  stateNext    = BREAK;
               end
            end
         end
         BREAK: begin
            // Wait out a stuck-low line so it cannot retrigger a frame
            if (rxS) begin
               counterNext   = '0;
               byteReadyNext = 1'b1;
               stateNext     = IDLE;
            end
         end
         default: begin
            stateNext   = IDLE;
            counterNext = '0;
         end
      endcase

      rxBusyNext = (stateNext != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 cycles/bit; received bytes are checked
// against a scoreboard queue filled as frames are driven.
module tb_uart_rx_byte;

   localparam int unsigned DF = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       uartRx;
   logic       byteReady;
   logic [7:0] data;
   logic       frameErr;
   logic       rxBusy;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic prevReady = 1'b1;
   int   lastFall = -1;
   int   lastRise = -1;
   int   fallCount = 0;
   int   riseCount = 0;
   bit   busySeen = 1'b0;

   uart_rx_byte #(.DELAY_FRAMES(DF)) dut (
      .clk       (clk),
      .reset     (reset),
      .uartRx    (uartRx),
      .byteReady (byteReady),
      .data      (data),
      .frameErr  (frameErr),
      .rxBusy    (rxBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // One clock step; samples 1 time unit after the edge and tracks the handshake
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (rxBusy) busySeen = 1'b1;
      if (!reset && prevReady && !byteReady) begin
         lastFall = cyc;
         fallCount++;
      end
      if (!reset && !prevReady && byteReady) begin
         lastRise = cyc;
         riseCount++;
         if (sb.size() == 0) begin
            check("sbNonEmptyAtRise", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("rxData", 32'(data), 32'(e.data));
            check("rxFrameErr", 32'(frameErr), 32'(e.err));
         end
      end
      prevReady = byteReady;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic sendBit(input logic b);
      uartRx = b;
      repeat (DF) tick();
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int startCyc);
      exp_t e;
      e.data = b;
      e.err  = ~stopBit;
      sb.push_back(e);
      startCyc = cyc;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(stopBit);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check("sbDrained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int s;
      int f0;
      int r0;
      int rel;

      reset  = 1'b1;
      uartRx = 1'b1;
      idle(3);
      check("rstReady", 32'(byteReady), 32'd1);
      check("rstData", 32'(data), 32'h00);
      check("rstFrameErr", 32'(frameErr), 32'd0);
      check("rstBusy", 32'(rxBusy), 32'd0);
      reset = 1'b0;

      // Idle line stays quiet
      for (int i = 0; i < 100; i++) begin
         tick();
         check("idleOutputs", 32'({byteReady, data, frameErr, rxBusy}), 32'({1'b1, 8'h00, 1'b0, 1'b0}));
      end

      // Single byte with latency checks
      sendFrame(8'h41, 1'b1, s);
      checkRange("fallLatency", lastFall - s, 10, 12);
      checkRange("riseLatency", lastRise - s, 154, 156);
      check("dataA", 32'(data), 32'h41);
      check("frameErrA", 32'(frameErr), 32'd0);
      check("fallsA", 32'(fallCount), 32'd1);
      check("risesA", 32'(riseCount), 32'd1);
      drain(5);

      // Back-to-back frames, no idle gap
      f0 = fallCount;
      r0 = riseCount;
      sendFrame(8'h48, 1'b1, s);
      sendFrame(8'h69, 1'b1, s);
      drain(20);
      check("b2bFalls", 32'(fallCount - f0), 32'd2);
      check("b2bRises", 32'(riseCount - r0), 32'd2);
      check("b2bData", 32'(data), 32'h69);

      // Short glitch is rejected as a false start
      idle(10);
      busySeen = 1'b0;
      f0 = fallCount;
      uartRx = 1'b0;
      idle(4);
      uartRx = 1'b1;
      idle(30);
      check("glitchFalls", 32'(fallCount), 32'(f0));
      check("glitchReady", 32'(byteReady), 32'd1);
      check("glitchData", 32'(data), 32'h69);
      check("glitchBusyIdle", 32'(rxBusy), 32'd0);
      check("glitchBusySeen", 32'(busySeen), 32'd1);

      // Low stop bit then held-low line (break)
      sendFrame(8'h55, 1'b0, s);
      uartRx = 1'b0;
      idle(50);
      check("breakFrameErr", 32'(frameErr), 32'd1);
      check("breakData", 32'(data), 32'h55);
      check("breakReadyLow", 32'(byteReady), 32'd0);
      check("breakBusy", 32'(rxBusy), 32'd1);
      rel = cyc;
      uartRx = 1'b1;
      idle(10);
      checkRange("breakReleaseLatency", lastRise - rel, 2, 4);
      drain(5);
      sendFrame(8'h0A, 1'b1, s);
      drain(20);
      check("recoverFrameErr", 32'(frameErr), 32'd0);
      check("recoverData", 32'(data), 32'h0A);

      // Reset in the middle of bit 4 aborts the frame
      idle(5);
      uartRx = 1'b0;
      idle(DF);
      for (int i = 0; i < 4; i++) sendBit(1'b1 ^ i[0]);
      uartRx = 1'b0;
      idle(DF / 2);
      check("midFrameReadyLow", 32'(byteReady), 32'd0);
      reset = 1'b1;
      tick();
      check("abortReady", 32'(byteReady), 32'd1);
      check("abortData", 32'(data), 32'h00);
      check("abortBusy", 32'(rxBusy), 32'd0);
      check("abortFrameErr", 32'(frameErr), 32'd0);
      reset  = 1'b0;
      uartRx = 1'b1;
      idle(5);
      check("abortStaysIdle", 32'(rxBusy), 32'd0);
      sendFrame(8'h7E, 1'b1, s);
      drain(20);
      check("postResetData", 32'(data), 32'h7E);
      check("postResetFrameErr", 32'(frameErr), 32'd0);
      idle(20);
      check("finalQueueEmpty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
